// File: rtl/lane_reset_sequencer.sv
// Sequences reset release across LANES lane endpoints: hold all lanes, then release one per GAP cycles.
// Outputs registered; start is captured one cycle before use. Define LRS_REVERSE_EN to release from LANES-1 down to 0.
module lane_reset_sequencer #(
    parameter int LANES    = 4,
    parameter int HOLD_CYC = 2,
    parameter int GAP      = 3,
    parameter int LW       = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic [LANES-1:0] lane_rst,
    output logic             busy,
    output logic             done,
    output logic [LW-1:0]    cur_lane
);

    localparam int MAXC = (HOLD_CYC > GAP) ? HOLD_CYC : GAP;
    localparam int CW   = $clog2(MAXC) + 1;
`ifdef LRS_REVERSE_EN
    localparam logic [LW-1:0] FIRST = LW'(LANES - 1);
    localparam logic [LW-1:0] LAST  = '0;
`else
    localparam logic [LW-1:0] FIRST = '0;
    localparam logic [LW-1:0] LAST  = LW'(LANES - 1);
`endif

    typedef enum logic [1:0] {IDLE, HOLD, REL, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             start_q;
    logic [LANES-1:0] lane_rst_q;
    logic             busy_q;
    logic             done_q;
    logic [LW-1:0]    cur_lane_q;

    logic [LW-1:0]    cur_lane_d;
    logic [LANES-1:0] rel_mask_d;

    // cur_lane saturates on the last lane instead of wrapping
    always_comb begin
        cur_lane_d = cur_lane_q;
        if (cur_lane_q != LAST) begin
`ifdef LRS_REVERSE_EN
            cur_lane_d = cur_lane_q - 1'b1;
`else
            cur_lane_d = cur_lane_q + 1'b1;
`endif
        end
        rel_mask_d = lane_rst_q & ~(LANES'(1) << cur_lane_q);
    end

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            start_q    <= 1'b0;
            lane_rst_q <= '1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cur_lane_q <= FIRST;
        end else begin
            start_q <= start;
            unique case (state_q)
                IDLE: begin
                    if (start_q) begin
                        state_q <= HOLD;
                        busy_q  <= 1'b1;
                        cnt_q   <= CW'(HOLD_CYC - 1);
                    end
                end
                HOLD, REL: begin
                    // all lanes out: finish one edge after the last release
                    if (state_q == REL && lane_rst_q == '0) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (cnt_q == '0) begin
                        state_q    <= REL;
                        lane_rst_q <= rel_mask_d;
                        cur_lane_q <= cur_lane_d;
                        cnt_q      <= CW'(GAP - 1);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (start_q) begin
                        state_q    <= HOLD;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        lane_rst_q <= '1;
                        cur_lane_q <= FIRST;
                        cnt_q      <= CW'(HOLD_CYC - 1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lane_rst = lane_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cur_lane = cur_lane_q;

endmodule

// File: tb/tb_lane_reset_sequencer.sv
// Bench for lane_reset_sequencer: a 4-lane and a 1-lane instance share stimulus; a timing-formula model predicts outputs.
module tb_lane_reset_sequencer;

    logic clk = 1'b0;
    logic reset, start, abort;
    logic [3:0] lr0;
    logic       busy0, done0;
    logic [1:0] cur0;
    logic [0:0] lr1;
    logic       busy1, done1;
    logic [0:0] cur1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    localparam int PL[2] = '{4, 1};
    localparam int PH[2] = '{2, 1};
    localparam int PG[2] = '{3, 1};

    bit m_act[2];
    bit m_sq[2];
    int m_k[2];

    always #5 clk = ~clk;

    lane_reset_sequencer #(.LANES(4), .HOLD_CYC(2), .GAP(3)) dut0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .lane_rst(lr0), .busy(busy0), .done(done0), .cur_lane(cur0));

    lane_reset_sequencer #(.LANES(1), .HOLD_CYC(1), .GAP(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .lane_rst(lr1), .busy(busy1), .done(done1), .cur_lane(cur1));

    function automatic int ordf(int j, int L);
`ifdef LRS_REVERSE_EN
        return L - 1 - j;
`else
        return j;
`endif
    endfunction

    // Packed view {lane_rst[15:0], busy, done, cur_lane[3:0]}
    function automatic logic [21:0] got(int i);
        if (i == 0) return {12'b0, lr0, busy0, done0, 2'b0, cur0};
        return {15'b0, lr1, busy1, done1, 3'b0, cur1};
    endfunction

    function automatic int seq_len(int i);
        return 1 + PH[i] + (PL[i] - 1) * PG[i];
    endfunction

    // Expected outputs from the release-timing rules relative to the edge the sequence began (m_k)
    function automatic logic [21:0] mdl(int i);
        int L, e, n;
        logic [15:0] lr;
        logic b;
        L  = PL[i];
        lr = 16'((32'd1 << L) - 1);
        if (!m_act[i]) return {lr, 2'b00, 4'(ordf(0, L))};
        e = cyc - m_k[i];
        n = (e < PH[i]) ? 0 : (e - PH[i]) / PG[i] + 1;
        if (n > L) n = L;
        for (int j = 0; j < n; j++) lr[ordf(j, L)] = 1'b0;
        b = (e < seq_len(i));
        return {lr, b, !b, 4'(ordf((n < L) ? n : L - 1, L))};
    endfunction

    task automatic step(input logic s, input logic a, input logic r);
        bit done_prev;
        start = s; abort = a; reset = r;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            done_prev = m_act[i] && ((cyc - 1 - m_k[i]) >= seq_len(i));
            if (r || a) begin
                m_act[i] = 1'b0;
                m_sq[i]  = 1'b0;
            end else begin
                if (m_sq[i] && (!m_act[i] || done_prev)) begin
                    m_act[i] = 1'b1;
                    m_k[i]   = cyc;
                end
                m_sq[i] = s;
            end
        end
        #1;
    endtask

`ifdef LRS_REVERSE_EN
    localparam logic [21:0] RST0 = {12'b0, 4'hF, 2'b00, 4'd3};
`else
    localparam logic [21:0] RST0 = {12'b0, 4'hF, 2'b00, 4'd0};
`endif
    localparam logic [21:0] RST1 = {15'b0, 1'b1, 2'b00, 4'd0};

    task automatic test_reset();
        step(0, 0, 1);
        step(0, 0, 1);
        checks++;
        if (got(0) !== RST0) begin errors++; $display("FAIL reset0 got %h exp %h", got(0), RST0); end
        checks++;
        if (got(1) !== RST1) begin errors++; $display("FAIL reset1 got %h exp %h", got(1), RST1); end
        step(0, 0, 0);
        step(0, 1, 0);
        checks++;
        if (got(0) !== RST0) begin errors++; $display("FAIL idle_abort got %h exp %h", got(0), RST0); end
    endtask

    task automatic test_directed();
        logic [3:0] tab[5];
        logic [21:0] e0, e1;
        int grp;
`ifdef LRS_REVERSE_EN
        tab = '{4'hF, 4'h7, 4'h3, 4'h1, 4'h0};
`else
        tab = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
`endif
        step(1, 0, 0);
        for (int i = 1; i <= 14; i++) begin
            step(0, 0, 0);
            grp = (i < 3) ? 0 : (i - 3) / 3 + 1;
            if (grp > 4) grp = 4;
            e0 = {12'b0, tab[grp], 1'(i < 13), 1'(i >= 13), 4'(ordf((grp < 4) ? grp : 3, 4))};
            e1 = {15'b0, 1'(i < 2), 1'(i < 3), 1'(i >= 3), 4'd0};
            checks++;
            if (got(0) !== e0) begin errors++; $display("FAIL directed0 i=%0d got %h exp %h", i, got(0), e0); end
            checks++;
            if (got(1) !== e1) begin errors++; $display("FAIL directed1 i=%0d got %h exp %h", i, got(1), e1); end
        end
    endtask

    task automatic test_abort();
        step(1, 0, 0);
        for (int i = 1; i <= 7; i++) step(0, 0, 0);
        step(1, 1, 0);
        checks++;
        if (got(0) !== RST0) begin errors++; $display("FAIL abort_mid got %h exp %h", got(0), RST0); end
        checks++;
        if (got(1) !== RST1) begin errors++; $display("FAIL abort_done1 got %h exp %h", got(1), RST1); end
        step(0, 0, 0);
        checks++;
        if ({busy0, busy1} !== 2'b00) begin errors++; $display("FAIL abort_nostart got %b exp 00", {busy0, busy1}); end
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        checks++;
        if (lr0 !== 4'hF) begin errors++; $display("FAIL restart_hold got %h exp f", lr0); end
        step(0, 0, 0);
        checks++;
        if (got(0) !== mdl(0) || lr0 === 4'hF) begin
            errors++; $display("FAIL restart_rel got %h exp %h", got(0), mdl(0));
        end
    endtask

    task automatic test_start_held();
        int rises = 0;
        logic pb = busy0;
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 0);
            if (busy0 && !pb) rises++;
            pb = busy0;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got(k) !== mdl(k)) begin errors++; $display("FAIL held%0d cyc %0d got %h exp %h", k, cyc, got(k), mdl(k)); end
            end
        end
        checks++;
        if (rises !== 3) begin errors++; $display("FAIL held_seq_count got %0d exp 3", rises); end
        for (int i = 0; i < 3; i++) step(0, 0, 0);
    endtask

    task automatic test_reset_mid();
        step(0, 1, 0);
        step(1, 0, 0);
        for (int i = 1; i <= 6; i++) step(0, 0, 0);
        step(1, 0, 1);
        checks++;
        if (got(0) !== RST0) begin errors++; $display("FAIL reset_mid0 got %h exp %h", got(0), RST0); end
        checks++;
        if (got(1) !== RST1) begin errors++; $display("FAIL reset_mid1 got %h exp %h", got(1), RST1); end
        step(1, 0, 0);
        checks++;
        if ({busy0, busy1} !== 2'b00) begin errors++; $display("FAIL reset_quiet got %b exp 00", {busy0, busy1}); end
        step(0, 0, 0);
        checks++;
        if (got(0) !== mdl(0) || busy0 !== 1'b1) begin errors++; $display("FAIL reset_restart got %h exp %h", got(0), mdl(0)); end
    endtask

    task automatic test_random();
        logic s, a, r;
        for (int i = 0; i < 600; i++) begin
            s = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 24) == 0);
            r = ($urandom_range(0, 59) == 0);
            step(s, a, r);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got(k) !== mdl(k)) begin errors++; $display("FAIL random%0d cyc %0d got %h exp %h", k, cyc, got(k), mdl(k)); end
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        m_act = '{1'b0, 1'b0}; m_sq = '{1'b0, 1'b0}; m_k = '{0, 0};
        test_reset();
        test_directed();
        test_abort();
        test_start_held();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_reset_sequencer.md
# lane_reset_sequencer

Controller that sequences reset release across a bank of per-lane registered endpoints, the generate-for replicated flops that each take a dedicated reset input. On a start request it holds every lane in reset for a programmable interval, then releases lanes one at a time at a fixed spacing. It flags completion and supports abort. It sits between the testbench/system reset logic and the lane array, replacing ad-hoc cycle-count reset sequencing.

## Interface
Parameters:
- LANES, 4: number of lanes sequenced; legal range 1..16.
- HOLD_CYC, 2: cycles all lanes stay in reset after start before the first release; must be ≥1.
- GAP, 3: cycles between consecutive lane releases; must be ≥1.
- LW, $clog2(LANES) (min 1): width of cur_lane.

Ports:
- clk  input  1  sole clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level-sampled request to begin a sequence.
- abort  input  1  level-sampled request to cancel and re-assert all lane resets.
- lane_rst  output  LANES  per-lane reset, active-high; bit i drives lane i.
- busy  output  1  sequence in progress.
- done  output  1  all lanes released; held until next start/abort/reset.
- cur_lane  output  LW  index of the next lane to be released.

One clock; reset is synchronous and active-high. Ports are named clk and reset.

## Operation
- FSM states: IDLE, HOLD, REL, DONE.
- Reset values: state IDLE, lane_rst all ones, busy 0, done 0, cur_lane = first lane index (0, or LANES-1 under LRS_REVERSE_EN), internal counter 0.
- IDLE: lane_rst all ones. start=1 → HOLD, busy=1, counter loaded with HOLD_CYC-1.
- HOLD: counter decrements each cycle. At 0 → REL, clear lane_rst[cur_lane], load counter GAP-1, advance cur_lane.
- REL: counter decrements. At 0, if lanes remain → clear lane_rst[cur_lane], reload GAP-1, advance. After the last lane is cleared → DONE on the following edge.
- DONE: busy=0, done=1, lane_rst all zeros. start=1 → HOLD (re-sequence; lane_rst returns to all ones), done=0.
- abort=1 in HOLD/REL/DONE → IDLE next edge: lane_rst all ones, busy 0, done 0, cur_lane to first index. abort in IDLE has no effect.
- start while busy is ignored. abort and start in the same cycle: abort wins.
- Released lanes never re-enter reset mid-sequence except via abort or reset.
- cur_lane saturates at the last index once all lanes are released; it does not wrap.
- Counter width: $clog2(max(HOLD_CYC,GAP))+1 bits, with no overflow for the legal parameter ranges.

## Timing
- start sampled high at edge k → busy=1 after edge k+1.
- Lane j (j-th in release order, from 0) clears at edge k+1+HOLD_CYC+j·GAP.
- done rises and busy falls at edge k+2+HOLD_CYC+(LANES-1)·GAP.
- LANES=1: single release at k+1+HOLD_CYC, done one edge later.
- abort or reset at edge m → all outputs at reset values after edge m, regardless of state.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- LRS_REVERSE_EN defined: release order is LANES-1 down to 0, and cur_lane resets to LANES-1 and decrements.
- LRS_REVERSE_EN undefined: release order is 0 up to LANES-1, and cur_lane resets to 0 and increments.
- Timing formulas are unchanged in both modes; only the order changes.

## Test plan
- LANES=4, HOLD_CYC=2, GAP=3, start pulsed at edge 5 → busy=1 at 6; lane_rst 1111→1110 @8, 1100 @11, 1000 @14, 0000 @17; done=1, busy=0 @18.
- Same configuration with LRS_REVERSE_EN → lane_rst 0111 @8, 0011 @11, 0001 @14, 0000 @17; cur_lane 3,2,1,0.
- abort at edge 12 mid-sequence → lane_rst=1111, busy=0, done=0, cur_lane=0 after edge 12. A new start at edge 15 → first release @18.
- start held high continuously through a sequence → exactly one sequence runs. In DONE with start still high, a re-sequence begins next edge: lane_rst=1111, done=0.
- reset asserted at edge 10 mid-REL (start=1 concurrently) → after edge 10 all outputs at reset values. No activity until start is sampled with reset low.
- LANES=1, HOLD_CYC=1, GAP=1, start at edge 2 → busy @3, lane_rst 1→0 @4, done @5; abort and start together at edge 7 → IDLE, lane_rst=1, busy stays 0.
